combat_scheduler: RTL and testbench
===================================

Name: combat_scheduler

Overview:
- Sequences the shared health-update datapath between two attack requesters: the player (decoded keyboard) and the CPU opponent.
- Arbitrates simultaneous requests, runs each attack through a windup, apply and cooldown sequence, and detects game over.
- Drives the health and attack-flag values consumed by the VGA display and seven-seg logic; it sits between the keyboard decoder and the display.

Parameters:
- MAX_HEALTH, 100, health reload value (must be 1..255).
- DAMAGE, 10, base damage per landed attack.
- WINDUP_CYCLES, 4, cycles an attack stays visible before it is applied (>=1).
- COOLDOWN_CYCLES, 8, cycles after apply during which new requests are ignored (>=1).
- BLOCK_SHIFT, 1, right-shift applied to damage when the defender is blocking.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; restarts the match from the OVER state
- p1_atk_req  in  1  player attack request (level)
- p1_block  in  1  player blocking (level)
- cpu_atk_req  in  1  CPU attack request (level)
- cpu_block  in  1  CPU blocking (level)
- p1_grant  out  1  one-cycle pulse when a player attack is accepted
- cpu_grant  out  1  one-cycle pulse when a CPU attack is accepted
- p1_isAttacking  out  1  high during the player windup
- cpu_isAttacking  out  1  high during the CPU windup
- p1_health_out  out  8  player health
- cpu_health_out  out  8  CPU health
- game_over  out  1  high in the OVER state
- p1_wins  out  1  valid while game_over is high; 1 = CPU health reached 0

Behaviour:
- Reset values: both healths = MAX_HEALTH; all other outputs 0; state READY; last_grant = CPU, so the player wins the first tie.
- All outputs are registered.
- FSM states: READY, WINDUP, APPLY, COOLDOWN, OVER.
- READY:
  - One request high: grant it.
  - Both high: grant the side not in last_grant (round-robin), then update last_grant.
  - Request sampled in cycle N gives the grant pulse and the isAttacking flag in cycle N+1.
- WINDUP:
  - Lasts exactly WINDUP_CYCLES cycles (N+1..N+WINDUP_CYCLES).
  - The attacker's isAttacking flag stays high throughout.
  - Requests are ignored.
- APPLY (one cycle, N+WINDUP_CYCLES+1):
  - The defender's block input is sampled in this cycle.
  - dmg = DAMAGE when not blocking; dmg = DAMAGE >> BLOCK_SHIFT when blocking.
  - The defender's health saturates at 0: new = (h > dmg) ? h − dmg : 0.
  - The new value is visible from the next cycle.
  - If the new value is 0, go to OVER; otherwise go to COOLDOWN.
- COOLDOWN:
  - Lasts COOLDOWN_CYCLES cycles, then returns to READY.
  - Requests held through cooldown are granted on the first READY cycle.
- OVER:
  - game_over = 1; p1_wins = (cpu_health_out == 0); no grants are issued.
  - start reloads both healths, clears game_over and p1_wins, and enters READY next cycle.
  - start in any other state is ignored.
- The attacker never loses health; the attacker's own block input is ignored.
- Timing with default parameters and a request at cycle 0:
  - grant in cycle 1; isAttacking cycles 1–4; APPLY in cycle 5.
  - new health visible in cycle 6; COOLDOWN cycles 6–13; READY in cycle 14.
- Reset mid-sequence returns immediately to reset values; the in-flight attack is discarded with no damage.
- Counters are sized $clog2(max(WINDUP_CYCLES, COOLDOWN_CYCLES)+1).

Optional Feature:
- Macro COMBAT_CRIT_EN.
- Defined:
  - Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4), reset to 8'hA5, advancing every cycle.
  - In APPLY, if lfsr[2:0] == 3'b000, dmg is doubled before the saturating subtract.
  - The doubling also applies to blocked hits (the shift is applied first).
- Undefined: damage is fully deterministic and the LFSR is absent.

Decomposition:
- Package combat_pkg holds:
  - the state enum type;
  - HEALTH_W = 8;
  - the default MAX_HEALTH, DAMAGE, WINDUP_CYCLES and COOLDOWN_CYCLES constants;
  - the sat_sub function.
- One sub-module, phase_timer: a loadable down-counter with a load value and a done pulse. It is shared by WINDUP and COOLDOWN.

Test Plan:
- Reset, then p1_atk_req held for 1 cycle at cycle 0 → p1_grant in cycle 1; p1_isAttacking in cycles 1–4; cpu_health_out = 90 in cycle 6; READY in cycle 14.
- Both requests high on the same cycle, repeated → grants alternate P1, CPU, P1; each completes; both healths = 90 after the second attack.
- CPU attack with p1_block high during APPLY → p1_health_out drops 100 → 95; with p1_block high only during WINDUP → drops 100 → 90.
- Ten unblocked P1 attacks → cpu_health_out = 0; game_over = 1 and p1_wins = 1 from the next cycle; further requests give no grant; start → both healths 100, game_over = 0.
- Reset asserted during WINDUP (cycle 3) → outputs return to reset values asynchronously; no damage applied.
- COMBAT_CRIT_EN defined: force the LFSR state with lfsr[2:0] = 0 at APPLY → 20 damage, or 10 if blocked; CPU health at 15 with a crit hit → 0 (saturating).

Source files
------------

// File: rtl/combat_pkg.sv
// Shared types, defaults and helpers for the combat scheduler.
// Holds the FSM state type, health width, default timing/damage and sat_sub.
package combat_pkg;

   localparam int HEALTH_W = 8;

   localparam int DEF_MAX_HEALTH      = 100;
   localparam int DEF_DAMAGE          = 10;
   localparam int DEF_WINDUP_CYCLES   = 4;
   localparam int DEF_COOLDOWN_CYCLES = 8;

   // last_grant / attacker encoding
   localparam logic SIDE_P1  = 1'b0;
   localparam logic SIDE_CPU = 1'b1;

   typedef enum logic [2:0] {
      ST_READY    = 3'd0,
      ST_WINDUP   = 3'd1,
      ST_APPLY    = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_OVER     = 3'd4
   } state_t;

   // Health minus damage, clamped at zero; damage is one bit wider
   // so a doubled hit cannot wrap.
   function automatic logic [HEALTH_W-1:0] sat_sub(
      input logic [HEALTH_W-1:0] h,
      input logic [HEALTH_W:0]   d
   );
      logic [HEALTH_W:0] hx;
      logic [HEALTH_W:0] diff;
      hx   = {1'b0, h};
      diff = hx - d;
      return (hx > d) ? diff[HEALTH_W-1:0] : '0;
   endfunction

endpackage

// File: rtl/combat_scheduler_phase_timer.sv
// Loadable down-counter shared by the windup and cooldown phases.
// Ports: clk, reset, load, load_value -> done (high on the last counted cycle).
module phase_timer #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_value,
   output logic          done
);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - CW'(1);
      end
   end

   // A phase loaded with N spans N cycles: values N..1, done at 1.
   assign done = (count == CW'(1));

endmodule

// File: rtl/combat_scheduler.sv
// Arbitrates player/CPU attacks through windup, apply and cooldown phases,
// keeps both healths and detects game over. Optional macro: COMBAT_CRIT_EN.
// Ports: clk, reset, start, p1/cpu atk_req and block in;
//        grants, isAttacking flags, healths, game_over, p1_wins out.
module combat_scheduler
   import combat_pkg::*;
#(
   parameter int MAX_HEALTH      = DEF_MAX_HEALTH,
   parameter int DAMAGE          = DEF_DAMAGE,
   parameter int WINDUP_CYCLES   = DEF_WINDUP_CYCLES,
   parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
   parameter int BLOCK_SHIFT     = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                p1_atk_req,
   input  logic                p1_block,
   input  logic                cpu_atk_req,
   input  logic                cpu_block,
   output logic                p1_grant,
   output logic                cpu_grant,
   output logic                p1_isAttacking,
   output logic                cpu_isAttacking,
   output logic [HEALTH_W-1:0] p1_health_out,
   output logic [HEALTH_W-1:0] cpu_health_out,
   output logic                game_over,
   output logic                p1_wins
);

   localparam int CNT_MAX = (WINDUP_CYCLES > COOLDOWN_CYCLES) ?
                            WINDUP_CYCLES : COOLDOWN_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);

   localparam logic [HEALTH_W-1:0] H_MAX    = HEALTH_W'(MAX_HEALTH);
   localparam logic [HEALTH_W:0]   DMG_FULL = (HEALTH_W+1)'(DAMAGE);
   localparam logic [HEALTH_W:0]   DMG_BLK  =
      (HEALTH_W+1)'(DAMAGE >> BLOCK_SHIFT);

   state_t              state;
   logic                last_grant;
   logic                p1_pick;
   logic                cpu_pick;
   logic                timer_load;
   logic [CW-1:0]       timer_val;
   logic                timer_done;
   logic                def_block;
   logic [HEALTH_W-1:0] def_health;
   logic [HEALTH_W:0]   dmg;
   logic [HEALTH_W-1:0] new_health;

   // Player takes the slot when alone, or on a tie if the CPU went last.
   assign p1_pick  = p1_atk_req & (~cpu_atk_req | (last_grant == SIDE_CPU));
   assign cpu_pick = cpu_atk_req & ~p1_pick;

   // READY loads the windup length; APPLY loads the cooldown length.
   assign timer_load = ((state == ST_READY) & (p1_pick | cpu_pick)) |
                       (state == ST_APPLY);
   assign timer_val  = (state == ST_READY) ? CW'(WINDUP_CYCLES)
                                           : CW'(COOLDOWN_CYCLES);

   phase_timer #(
      .CW (CW)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_val),
      .done       (timer_done)
   );

   // last_grant doubles as the current attacker; the other side defends.
   assign def_block  = (last_grant == SIDE_CPU) ? p1_block : cpu_block;
   assign def_health = (last_grant == SIDE_CPU) ? p1_health_out
                                                : cpu_health_out;

`ifdef COMBAT_CRIT_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   // Block shift first, then the crit doubles whatever is left.
   always_comb begin
      dmg = def_block ? DMG_BLK : DMG_FULL;
      if (lfsr[2:0] == 3'b000) begin
         dmg = {dmg[HEALTH_W-1:0], 1'b0};
      end
   end
`else
   always_comb begin
      dmg = def_block ? DMG_BLK : DMG_FULL;
   end
`endif

   assign new_health = sat_sub(def_health, dmg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= ST_READY;
         last_grant      <= SIDE_CPU;
         p1_grant        <= 1'b0;
         cpu_grant       <= 1'b0;
         p1_isAttacking  <= 1'b0;
         cpu_isAttacking <= 1'b0;
         p1_health_out   <= H_MAX;
         cpu_health_out  <= H_MAX;
         game_over       <= 1'b0;
         p1_wins         <= 1'b0;
      end else begin
         p1_grant  <= 1'b0;
         cpu_grant <= 1'b0;
         unique case (state)
            ST_READY: begin
               if (p1_pick) begin
                  p1_grant       <= 1'b1;
                  p1_isAttacking <= 1'b1;
                  last_grant     <= SIDE_P1;
                  state          <= ST_WINDUP;
               end else if (cpu_pick) begin
                  cpu_grant       <= 1'b1;
                  cpu_isAttacking <= 1'b1;
                  last_grant      <= SIDE_CPU;
                  state           <= ST_WINDUP;
               end
            end
            ST_WINDUP: begin
               if (timer_done) begin
                  p1_isAttacking  <= 1'b0;
                  cpu_isAttacking <= 1'b0;
                  state           <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               if (last_grant == SIDE_CPU) begin
                  p1_health_out <= new_health;
               end else begin
                  cpu_health_out <= new_health;
               end
               if (new_health == '0) begin
                  game_over <= 1'b1;
                  p1_wins   <= (last_grant == SIDE_P1);
                  state     <= ST_OVER;
               end else begin
                  state <= ST_COOLDOWN;
               end
            end
            ST_COOLDOWN: begin
               if (timer_done) begin
                  state <= ST_READY;
               end
            end
            ST_OVER: begin
               if (start) begin
                  p1_health_out  <= H_MAX;
                  cpu_health_out <= H_MAX;
                  game_over      <= 1'b0;
                  p1_wins        <= 1'b0;
                  state          <= ST_READY;
               end
            end
            default: state <= ST_READY;
         endcase
      end
   end

endmodule

// File: tb/tb_combat_scheduler.sv
// Randomized scoreboard bench for combat_scheduler (default build).
// Stimulus pushes per-attack expectations; a monitor pops them on each grant.
module tb_combat_scheduler;

   localparam int W    = 4;
   localparam int C    = 8;
   localparam int MAXH = 100;
   localparam int DMG  = 10;
   localparam int BSH  = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       p1_atk_req;
   logic       p1_block;
   logic       cpu_atk_req;
   logic       cpu_block;
   logic       p1_grant;
   logic       cpu_grant;
   logic       p1_isAttacking;
   logic       cpu_isAttacking;
   logic [7:0] p1_health_out;
   logic [7:0] cpu_health_out;
   logic       game_over;
   logic       p1_wins;

   combat_scheduler dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .p1_atk_req      (p1_atk_req),
      .p1_block        (p1_block),
      .cpu_atk_req     (cpu_atk_req),
      .cpu_block       (cpu_block),
      .p1_grant        (p1_grant),
      .cpu_grant       (cpu_grant),
      .p1_isAttacking  (p1_isAttacking),
      .cpu_isAttacking (cpu_isAttacking),
      .p1_health_out   (p1_health_out),
      .cpu_health_out  (cpu_health_out),
      .game_over       (game_over),
      .p1_wins         (p1_wins)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit cpu_side;
      int p1_before;
      int cpu_before;
      int p1_after;
      int cpu_after;
      bit over;
      bit p1w;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;

   // Reference model state: healths and who attacked last.
   int   m_p1 = MAXH;
   int   m_cpu = MAXH;
   bit   m_last_cpu = 1'b1;

   task automatic check(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_drive();
      p1_atk_req  = 1'($urandom % 2);
      cpu_atk_req = 1'($urandom % 2);
      p1_block    = 1'($urandom % 2);
      cpu_block   = 1'($urandom % 2);
      start       = 1'($urandom % 2);
   endtask

   task automatic idle(input int n);
      p1_atk_req  = 1'b0;
      cpu_atk_req = 1'b0;
      repeat (n) begin
         p1_block  = 1'($urandom % 2);
         cpu_block = 1'($urandom % 2);
         start     = 1'($urandom % 2);
         step();
      end
      start = 1'b0;
   endtask

   // Called in a READY cycle; returns in the next READY cycle.
   task automatic attack(input bit p1r, input bit cpur, input bit blk);
      exp_t e;
      int   d;
      bit   cpu_side;
      cpu_side   = !(p1r && (!cpur || m_last_cpu));
      m_last_cpu = cpu_side;
      e.cpu_side   = cpu_side;
      e.p1_before  = m_p1;
      e.cpu_before = m_cpu;
      d = blk ? (DMG >> BSH) : DMG;
      if (cpu_side) m_p1 = (m_p1 > d) ? m_p1 - d : 0;
      else          m_cpu = (m_cpu > d) ? m_cpu - d : 0;
      e.p1_after  = m_p1;
      e.cpu_after = m_cpu;
      e.over      = (m_p1 == 0) || (m_cpu == 0);
      e.p1w       = (m_cpu == 0);
      sbq.push_back(e);

      p1_atk_req  = p1r;
      cpu_atk_req = cpur;
      p1_block    = 1'($urandom % 2);
      cpu_block   = 1'($urandom % 2);
      start       = 1'b0;
      step();
      repeat (W) begin
         rnd_drive();
         step();
      end
      rnd_drive();
      if (cpu_side) p1_block = blk;
      else          cpu_block = blk;
      step();
      if (e.over) begin
         repeat (3) begin
            rnd_drive();
            start = 1'b0;
            @(negedge clk);
            check("over_flag", int'(game_over), 1);
            check("over_p1_wins", int'(p1_wins), int'(e.p1w));
            check("over_no_grant", int'(p1_grant | cpu_grant), 0);
            step();
         end
         rnd_drive();
         start = 1'b1;
         step();
         p1_atk_req  = 1'b0;
         cpu_atk_req = 1'b0;
         start       = 1'b0;
         @(negedge clk);
         check("restart_p1_h", int'(p1_health_out), MAXH);
         check("restart_cpu_h", int'(cpu_health_out), MAXH);
         check("restart_over", int'(game_over), 0);
         check("restart_wins", int'(p1_wins), 0);
         m_p1  = MAXH;
         m_cpu = MAXH;
         step();
      end else begin
         repeat (C) begin
            rnd_drive();
            step();
         end
         p1_atk_req  = 1'b0;
         cpu_atk_req = 1'b0;
         start       = 1'b0;
      end
   endtask

   // Monitor: every grant must match the oldest expected attack.
   initial begin
      forever begin
         @(negedge clk);
         if (!mon_en) continue;
         if (p1_grant || cpu_grant) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_grant: p1_grant=%0d cpu_grant=%0d, none required (t=%0t)",
                        p1_grant, cpu_grant, $time);
            end else begin
               mon_e = sbq.pop_front();
               check("grant_p1", int'(p1_grant), int'(!mon_e.cpu_side));
               check("grant_cpu", int'(cpu_grant), int'(mon_e.cpu_side));
               for (int i = 0; i < W; i++) begin
                  if (i > 0) begin
                     @(negedge clk);
                     check("windup_no_grant", int'(p1_grant | cpu_grant), 0);
                  end
                  check("windup_p1_atk", int'(p1_isAttacking), int'(!mon_e.cpu_side));
                  check("windup_cpu_atk", int'(cpu_isAttacking), int'(mon_e.cpu_side));
                  check("windup_p1_h", int'(p1_health_out), mon_e.p1_before);
                  check("windup_cpu_h", int'(cpu_health_out), mon_e.cpu_before);
               end
               @(negedge clk);
               check("apply_atk", int'(p1_isAttacking | cpu_isAttacking), 0);
               check("apply_p1_h", int'(p1_health_out), mon_e.p1_before);
               check("apply_cpu_h", int'(cpu_health_out), mon_e.cpu_before);
               @(negedge clk);
               check("post_p1_h", int'(p1_health_out), mon_e.p1_after);
               check("post_cpu_h", int'(cpu_health_out), mon_e.cpu_after);
               check("post_over", int'(game_over), int'(mon_e.over));
               check("post_wins", int'(p1_wins), int'(mon_e.p1w));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   initial begin
      int pat;
      reset       = 1'b1;
      start       = 1'b0;
      p1_atk_req  = 1'b0;
      cpu_atk_req = 1'b0;
      p1_block    = 1'b0;
      cpu_block   = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_p1_h", int'(p1_health_out), MAXH);
      check("rst_cpu_h", int'(cpu_health_out), MAXH);
      check("rst_grant", int'(p1_grant | cpu_grant), 0);
      check("rst_atk", int'(p1_isAttacking | cpu_isAttacking), 0);
      check("rst_over", int'(game_over | p1_wins), 0);

      // Attack aborted by reset in the middle of windup.
      step();
      p1_atk_req = 1'b1;
      step();
      p1_atk_req = 1'b0;
      @(negedge clk);
      check("abort_grant", int'(p1_grant), 1);
      check("abort_atk_c1", int'(p1_isAttacking), 1);
      step();
      step();
      #2 reset = 1'b1;
      #1;
      check("async_atk", int'(p1_isAttacking), 0);
      check("async_cpu_h", int'(cpu_health_out), MAXH);
      step();
      reset = 1'b0;
      repeat (12) step();
      @(negedge clk);
      check("abort_no_dmg", int'(cpu_health_out), MAXH);
      check("abort_idle", int'(p1_isAttacking | game_over), 0);
      step();
      mon_en = 1'b1;

      // Ties alternate from a player-first reset state.
      attack(1'b1, 1'b1, 1'b0);
      attack(1'b1, 1'b1, 1'b0);
      attack(1'b1, 1'b1, 1'b0);
      // Blocked and unblocked CPU hits.
      attack(1'b0, 1'b1, 1'b1);
      attack(1'b0, 1'b1, 1'b0);
      // Player hammers the CPU down to zero.
      for (int k = 0; k < 20 && m_cpu > 0; k++) attack(1'b1, 1'b0, 1'b0);
      idle(2);

      repeat (70) begin
         pat = $urandom_range(1, 3);
         if ($urandom % 4 == 0) idle($urandom_range(1, 3));
         attack(pat[0], pat[1], 1'($urandom % 2));
      end

      idle(20);
      check("scoreboard_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
